// File: rtl/apb_slave_regfile.sv
// APB slave register file: reg 0 is a read-only ID, regs 1..REG_NUM-1 are byte-strobed R/W; optional PSLVERR under `APB_SLV_ERR_EN.
// Latency: PREADY rises in ACCESS cycle WAIT_CYCLES+1 (WAIT_CYCLES=0 gives zero wait states).
// Backpressure: PREADY is held low for WAIT_CYCLES access cycles; dropping PSEL in ACCESS aborts with no commit.
module apb_slave_regfile #(
   parameter int          DATA_WIDTH  = 32,
   parameter int          ADDR_WIDTH  = 32,
   parameter int          REG_NUM     = 16,
   parameter int          WAIT_CYCLES = 2,
   parameter logic [31:0] ID_VAL      = 32'hA5B0_0001
) (
   input  logic                    PCLK,
   input  logic                    PRESET,
   input  logic                    PSEL,
   input  logic                    PENABLE,
   input  logic                    PWRITE,
   input  logic [ADDR_WIDTH-1:0]   PADDR,
   input  logic [DATA_WIDTH-1:0]   PWDATA,
   input  logic [DATA_WIDTH/8-1:0] PSTRB,
   output logic                    PREADY,
   output logic [DATA_WIDTH-1:0]   PRDATA
`ifdef APB_SLV_ERR_EN
   ,
   output logic                    PSLVERR
`endif
);

   localparam int IDX_W = $clog2(REG_NUM);
   localparam int NBYTE = DATA_WIDTH / 8;

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t                cs_q, cs_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] regs_q [REG_NUM];
   logic [DATA_WIDTH-1:0] regs_d [REG_NUM];

   logic [IDX_W-1:0]      idx;
   logic                  bad;
   logic                  commit;
   logic [DATA_WIDTH-1:0] rd_sel;

   assign idx    = PADDR[IDX_W+1:2];
   assign bad    = (PADDR[1:0] != 2'b00) || (PADDR[15:IDX_W+2] != '0) || (PWRITE && (idx == '0));
   assign PREADY = (cs_q == ACCESS) && (cnt_q == 4'd0);
   assign commit = PSEL && PENABLE && PREADY && PWRITE && !bad;

   always_comb begin
      cs_d  = cs_q;
      cnt_d = cnt_q;
      if (cs_q == IDLE) begin
         if (PSEL && !PENABLE) begin
            cs_d  = ACCESS;
            cnt_d = 4'(WAIT_CYCLES);
         end
      end else begin
         // completion and abort both end the transfer; only completion can commit
         if (!PSEL || (cnt_q == 4'd0)) begin
            cs_d  = IDLE;
            cnt_d = 4'd0;
         end else begin
            cnt_d = cnt_q - 4'd1;
         end
      end
   end

   always_comb begin
      regs_d = regs_q;
      if (commit) begin
         for (int k = 0; k < NBYTE; k++) begin
            if (PSTRB[k]) regs_d[idx][8*k +: 8] = PWDATA[8*k +: 8];
         end
      end
   end

   assign rd_sel = (idx == '0) ? ID_VAL[DATA_WIDTH-1:0] : regs_q[idx];
   assign PRDATA = (PREADY && !PWRITE && !bad) ? rd_sel : '0;

`ifdef APB_SLV_ERR_EN
   assign PSLVERR = PREADY && bad;
`endif

   generate
      if (ADDR_WIDTH > 16) begin : g_hi_addr
         logic unused_hi_addr;
         assign unused_hi_addr = ^PADDR[ADDR_WIDTH-1:16];
      end
   endgenerate

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         cs_q  <= IDLE;
         cnt_q <= 4'd0;
         for (int i = 0; i < REG_NUM; i++) regs_q[i] <= '0;
      end else begin
         cs_q  <= cs_d;
         cnt_q <= cnt_d;
         for (int i = 0; i < REG_NUM; i++) regs_q[i] <= regs_d[i];
      end
   end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed bench for apb_slave_regfile: a transfer-level model predicts PREADY/PRDATA/PSLVERR every cycle,
// and literal read-back values pin the model.
module tb_apb_slave_regfile;

   localparam int W = 2;

   logic        PCLK = 1'b0;
   logic        PRESET, PSEL, PENABLE, PWRITE;
   logic [31:0] PADDR, PWDATA;
   logic [3:0]  PSTRB;
   logic        PREADY;
   logic [31:0] PRDATA;
`ifdef APB_SLV_ERR_EN
   logic        PSLVERR;
`endif

   apb_slave_regfile #(
      .DATA_WIDTH(32), .ADDR_WIDTH(32), .REG_NUM(16), .WAIT_CYCLES(W), .ID_VAL(32'hA5B0_0001)
   ) dut (
      .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PREADY(PREADY), .PRDATA(PRDATA)
`ifdef APB_SLV_ERR_EN
      , .PSLVERR(PSLVERR)
`endif
   );

   always #5 PCLK = ~PCLK;

   int          n_chk  = 0;
   int          n_fail = 0;
   logic        chk_en = 1'b0;
   logic        exp_rdy, exp_err;
   logic [31:0] exp_rd;
   logic [31:0] mregs [16];
   logic [31:0] rd_cap;
   int          rdy_cycle;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge PCLK) begin
      if (chk_en) begin
         check("pready", {31'b0, PREADY}, {31'b0, exp_rdy});
         check("prdata", PRDATA, exp_rd);
`ifdef APB_SLV_ERR_EN
         check("pslverr", {31'b0, PSLVERR}, {31'b0, exp_err});
`endif
      end
   end

   function automatic logic is_bad(input logic [31:0] a, input logic wr);
      return (a[1:0] != 2'b00) || (a[15:0] >= 16'd64) || (wr && (a[15:0] < 16'd4));
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] a);
      int i;
      i = int'(a[15:0]) / 4;
      return (i == 0) ? 32'hA5B0_0001 : mregs[i];
   endfunction

   task automatic tick();
      @(posedge PCLK);
      #1;
   endtask

   task automatic exp_quiet();
      exp_rdy = 1'b0;
      exp_err = 1'b0;
      exp_rd  = 32'h0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         tick();
         PSEL    = 1'b0;
         PENABLE = 1'b0;
         exp_quiet();
      end
   endtask

   task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
      int idx;
      tick();
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = data; PSTRB = strb;
      exp_quiet();
      rdy_cycle = 0;
      for (int i = 1; i <= W + 1; i++) begin
         tick();
         PENABLE = 1'b1;
         exp_rdy = (i == W + 1);
         exp_err = exp_rdy && is_bad(addr, wr);
         exp_rd  = (exp_rdy && !wr && !is_bad(addr, wr)) ? model_read(addr) : 32'h0;
         #1;
         if (PREADY === 1'b1 && rdy_cycle == 0) rdy_cycle = i;
         if (i == W + 1) rd_cap = PRDATA;
      end
      if (wr && !is_bad(addr, wr)) begin
         idx = int'(addr[15:0]) / 4;
         for (int k = 0; k < 4; k++) if (strb[k]) mregs[idx][8*k +: 8] = data[8*k +: 8];
      end
   endtask

   initial begin
      PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
      PADDR = 32'h0; PWDATA = 32'h0; PSTRB = 4'h0;
      exp_quiet();
      rd_cap = 32'h0;
      for (int i = 0; i < 16; i++) mregs[i] = 32'h0;

      // outputs stay quiet while reset is held, even with a setup phase on the bus
      tick(); chk_en = 1'b1;
      PSEL = 1'b1;
      tick();
      tick(); PRESET = 1'b0; PSEL = 1'b0;
      idle(1);

      // PSEL & PENABLE together in IDLE must not start a transfer
      tick(); PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = 32'h0; exp_quiet();
      tick(); exp_quiet();

      xfer(1'b0, 32'h0, 32'h0, 4'h0);
      check("id_read", rd_cap, 32'hA5B0_0001);
      check("ready_cycle", rdy_cycle, 3);
      idle(1);

      xfer(1'b1, 32'h4, 32'h1122_3344, 4'b0101);
      idle(1);
      xfer(1'b0, 32'h4, 32'h0, 4'h0);
      check("strobe_read", rd_cap, 32'h0022_0044);

      xfer(1'b1, 32'h40, 32'hFFFF_FFFF, 4'hF);
      xfer(1'b0, 32'h40, 32'h0, 4'h0);
      check("range_read", rd_cap, 32'h0);

      xfer(1'b1, 32'h0, 32'h1234_5678, 4'hF);
      xfer(1'b0, 32'h0, 32'h0, 4'h0);
      check("id_ro", rd_cap, 32'hA5B0_0001);

      xfer(1'b1, 32'h5, 32'hFFFF_FFFF, 4'hF);
      xfer(1'b0, 32'h6, 32'h0, 4'h0);
      check("misalign_read", rd_cap, 32'h0);
      xfer(1'b0, 32'h4, 32'h0, 4'h0);
      check("misalign_wr", rd_cap, 32'h0022_0044);

      xfer(1'b1, 32'h3C, 32'hA1B2_C3D4, 4'b1000);
      xfer(1'b0, 32'h3C, 32'h0, 4'h0);
      check("last_reg", rd_cap, 32'hA100_0000);
      idle(2);

      // back-to-back: read setup directly follows the write completion
      xfer(1'b1, 32'h8, 32'hDEAD_BEEF, 4'hF);
      xfer(1'b0, 32'h8, 32'h0, 4'h0);
      check("b2b_read", rd_cap, 32'hDEAD_BEEF);

      // abort: PSEL dropped in the first access cycle
      tick(); PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'hC; PWDATA = 32'h55AA_55AA; PSTRB = 4'hF; exp_quiet();
      tick(); PSEL = 1'b0; PENABLE = 1'b1; exp_quiet();
      idle(3);
      xfer(1'b0, 32'hC, 32'h0, 4'h0);
      check("abort_read", rd_cap, 32'h0);
      idle(1);

      // reset lands on the last wait cycle of a write to reg1
      tick(); PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h4; PWDATA = 32'hCAFE_F00D; PSTRB = 4'hF; exp_quiet();
      tick(); PENABLE = 1'b1; exp_quiet();
      tick(); PRESET = 1'b1; exp_quiet();
      tick(); PRESET = 1'b0; exp_quiet();
      for (int i = 1; i < 16; i++) mregs[i] = 32'h0;
      idle(2);
      xfer(1'b0, 32'h4, 32'h0, 4'h0);
      check("reset_reg1", rd_cap, 32'h0);
      xfer(1'b0, 32'h8, 32'h0, 4'h0);
      check("reset_reg2", rd_cap, 32'h0);
      idle(2);

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
